mult6x6_sequencer: RTL

Sequential controller that computes a 6x6 unsigned product by time-multiplexing one combinational 2x3 array multiplier core. It splits operand `a` into three 2-bit digits and operand `b` into two 3-bit digits. Each cycle it drives one digit pair onto the core, then shifts and accumulates the 5-bit core result. The block sits between a start/done requester and the external core instance; the core itself holds no state.

---
 rtl/mult6x6_sequencer.sv | 111 +++++++++++
 1 files changed

// File: rtl/mult6x6_sequencer.sv
// mult6x6_sequencer: 6x6 unsigned multiply built from six passes through an
// external combinational 2x3 multiplier core. Operand a is split into three
// 2-bit digits and operand b into two 3-bit digits. Each RUN cycle selects one
// digit pair, shifts the 5-bit core result into place and accumulates it.
module mult6x6_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [5:0]  a,
  input  logic [5:0]  b,
  output logic        busy,
  output logic        done,
  output logic [11:0] product,
  output logic [1:0]  core_m,
  output logic [2:0]  core_q,
  input  logic [4:0]  core_p
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [5:0]  r_a;
  logic [5:0]  r_b;
  logic [11:0] r_acc;
  logic [11:0] r_product;
  logic [2:0]  r_idx;

  logic [1:0]  w_m;
  logic [2:0]  w_q;
  logic [2:0]  w_shift;
  logic [11:0] w_term;
  logic [11:0] w_sum;
  logic        w_accept;

  assign w_accept = (r_state == S_IDLE) && start;

  // Digit-pair select for the current step; order walks a's digits first, then b's.
  always_comb begin
    w_m     = 2'd0;
    w_q     = 3'd0;
    w_shift = 3'd0;
    if (r_state == S_RUN) begin
      case (r_idx)
        3'd0: begin w_m = r_a[1:0]; w_q = r_b[2:0]; w_shift = 3'd0; end
        3'd1: begin w_m = r_a[3:2]; w_q = r_b[2:0]; w_shift = 3'd2; end
        3'd2: begin w_m = r_a[5:4]; w_q = r_b[2:0]; w_shift = 3'd4; end
        3'd3: begin w_m = r_a[1:0]; w_q = r_b[5:3]; w_shift = 3'd3; end
        3'd4: begin w_m = r_a[3:2]; w_q = r_b[5:3]; w_shift = 3'd5; end
        3'd5: begin w_m = r_a[5:4]; w_q = r_b[5:3]; w_shift = 3'd7; end
        default: begin w_m = 2'd0; w_q = 3'd0; w_shift = 3'd0; end
      endcase
    end
  end

  // Weighted partial product; the largest term (21<<7) and total (3969) fit in 12 bits.
  assign w_term = {7'd0, core_p} << w_shift;
  assign w_sum  = r_acc + w_term;

  // Next-state logic for the IDLE -> RUN -> DONE -> IDLE cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_RUN;
      S_RUN:   if (r_idx == 3'd5) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Accumulator, step counter and result register; the last term lands directly in product.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc     <= 12'd0;
      r_idx     <= 3'd0;
      r_product <= 12'd0;
    end else if (w_accept) begin
      r_acc <= 12'd0;
      r_idx <= 3'd0;
    end else if (r_state == S_RUN) begin
      r_acc <= w_sum;
      r_idx <= r_idx + 3'd1;
      if (r_idx == 3'd5) r_product <= w_sum;
    end
  end

  // Operand capture on an accepted start; only these copies feed the core.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_a <= a;
      r_b <= b;
    end
  end

  assign busy    = (r_state != S_IDLE);
  assign done    = (r_state == S_DONE);
  assign product = r_product;
  assign core_m  = w_m;
  assign core_q  = w_q;

endmodule
